ips2l_pcie_dma_tlp_tx_arb: RTL and testbench

//  Packet-atomic arbiter: merges the three DMA TX AXIS streams onto one 128-bit AXIS TLP port.
//  The three streams are ch0 cpld, ch1 mrd and ch2 mwr.

---
 rtl/ips2l_pcie_dma_tlp_tx_arb.sv | 199 +++++++++++++++++++
 tb/tb_ips2l_pcie_dma_tlp_tx_arb.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ips2l_pcie_dma_tlp_tx_arb.sv
// Packet-atomic arbiter merging the cpld (ch0), mrd (ch1) and mwr (ch2) DMA TX streams
// onto one registered 128-bit AXIS TLP port; a grant is held until the granted tlast.
module ips2l_pcie_dma_tlp_tx_arb #(
  parameter int unsigned CPLD_PRIO      = 1,
  parameter int unsigned CPLD_BURST_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   i_ch_en,
  input  logic         i_s0_tvld,
  output logic         o_s0_trdy,
  input  logic [127:0] i_s0_tdata,
  input  logic         i_s0_tlast,
  input  logic         i_s0_tuser,
  input  logic         i_s1_tvld,
  output logic         o_s1_trdy,
  input  logic [127:0] i_s1_tdata,
  input  logic         i_s1_tlast,
  input  logic         i_s1_tuser,
  input  logic         i_s2_tvld,
  output logic         o_s2_trdy,
  input  logic [127:0] i_s2_tdata,
  input  logic         i_s2_tlast,
  input  logic         i_s2_tuser,
  output logic         o_m_tvld,
  input  logic         i_m_trdy,
  output logic [127:0] o_m_tdata,
  output logic         o_m_tlast,
  output logic         o_m_tuser,
  output logic [1:0]   o_grant,
  output logic         o_busy,
  input  logic         i_cnt_clr,
  output logic [15:0]  o_pkt_cnt0,
  output logic [15:0]  o_pkt_cnt1,
  output logic [15:0]  o_pkt_cnt2
);

  localparam logic [1:0] GRANT_NONE = 2'd3;

  typedef enum logic {IDLE, XFER} state_t;

  state_t       state_q, state_d;
  logic [1:0]   grant_q, grant_d;
  logic [1:0]   rr_ptr_q, rr_ptr_d;
  logic [3:0]   burst_q, burst_d;
  logic         m_tvld_q, m_tvld_d;
  logic [127:0] m_tdata_q, m_tdata_d;
  logic         m_tlast_q, m_tlast_d;
  logic         m_tuser_q, m_tuser_d;
  logic [15:0]  cnt_q [3];
  logic [15:0]  cnt_d [3];

  logic [2:0]   vld, last, req, trdy, hs, last_hs;
  logic         out_rdy;
  logic [1:0]   winner, idx;
  logic [127:0] sel_tdata;
  logic         sel_tlast, sel_tuser;

  assign vld     = {i_s2_tvld, i_s1_tvld, i_s0_tvld};
  assign last    = {i_s2_tlast, i_s1_tlast, i_s0_tlast};
  assign req     = vld & i_ch_en;
  assign out_rdy = ~m_tvld_q | i_m_trdy;

  always_comb begin
    trdy = '0;
    if (state_q == XFER) begin
      for (int unsigned n = 0; n < 3; n++) begin
        trdy[n] = (grant_q == 2'(n)) & out_rdy;
      end
    end
  end

  assign hs      = trdy & vld;
  assign last_hs = hs & last;

  always_comb begin
    case (grant_q)
      2'd1: begin
        sel_tdata = i_s1_tdata;
        sel_tlast = i_s1_tlast;
        sel_tuser = i_s1_tuser;
      end
      2'd2: begin
        sel_tdata = i_s2_tdata;
        sel_tlast = i_s2_tlast;
        sel_tuser = i_s2_tuser;
      end
      default: begin
        sel_tdata = i_s0_tdata;
        sel_tlast = i_s0_tlast;
        sel_tuser = i_s0_tuser;
      end
    endcase
  end

  always_comb begin
    winner = GRANT_NONE;
    idx    = '0;
    if (CPLD_PRIO != 0) begin
      if (req[0] && ((burst_q < 4'(CPLD_BURST_MAX)) || (req[2:1] == 2'b00))) begin
        winner = 2'd0;
      end else if (req[2:1] != 2'b00) begin
        if (rr_ptr_q == 2'd2) winner = req[2] ? 2'd2 : 2'd1;
        else                  winner = req[1] ? 2'd1 : 2'd2;
      end
    end else begin
      for (int unsigned k = 0; k < 3; k++) begin
        idx = 2'((32'(rr_ptr_q) + k) % 3);
        if ((winner == GRANT_NONE) && req[idx]) winner = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    burst_d  = burst_q;
    case (state_q)
      IDLE: begin
        if (winner != GRANT_NONE) begin
          state_d = XFER;
          grant_d = winner;
          if (winner == 2'd0) burst_d = (burst_q == 4'hF) ? burst_q : burst_q + 4'd1;
          else                burst_d = '0;
          // With ch0 priority the pointer only rotates ch1/ch2, so ch0 bursts leave it alone.
          if ((CPLD_PRIO == 0) || (winner != 2'd0)) begin
            rr_ptr_d = (winner == 2'd2) ? 2'd0 : winner + 2'd1;
          end
        end
      end
      XFER: begin
        if (|last_hs) begin
          state_d = IDLE;
          grant_d = GRANT_NONE;
        end
      end
    endcase
  end

  always_comb begin
    m_tvld_d  = m_tvld_q;
    m_tdata_d = m_tdata_q;
    m_tlast_d = m_tlast_q;
    m_tuser_d = m_tuser_q;
    if (|hs) begin
      m_tvld_d  = 1'b1;
      m_tdata_d = sel_tdata;
      m_tlast_d = sel_tlast;
      m_tuser_d = sel_tuser;
    end else if (i_m_trdy) begin
      m_tvld_d = 1'b0;
    end
  end

  always_comb begin
    for (int unsigned n = 0; n < 3; n++) begin
      cnt_d[n] = i_cnt_clr ? '0 : cnt_q[n] + 16'(last_hs[n]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= GRANT_NONE;
      rr_ptr_q  <= '0;
      burst_q   <= '0;
      m_tvld_q  <= 1'b0;
      m_tdata_q <= '0;
      m_tlast_q <= 1'b0;
      m_tuser_q <= 1'b0;
      for (int unsigned n = 0; n < 3; n++) cnt_q[n] <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      burst_q   <= burst_d;
      m_tvld_q  <= m_tvld_d;
      m_tdata_q <= m_tdata_d;
      m_tlast_q <= m_tlast_d;
      m_tuser_q <= m_tuser_d;
      for (int unsigned n = 0; n < 3; n++) cnt_q[n] <= cnt_d[n];
    end
  end

  assign o_s0_trdy  = trdy[0];
  assign o_s1_trdy  = trdy[1];
  assign o_s2_trdy  = trdy[2];
  assign o_m_tvld   = m_tvld_q;
  assign o_m_tdata  = m_tdata_q;
  assign o_m_tlast  = m_tlast_q;
  assign o_m_tuser  = m_tuser_q;
  assign o_grant    = grant_q;
  assign o_busy     = (state_q == XFER) | m_tvld_q;
  assign o_pkt_cnt0 = cnt_q[0];
  assign o_pkt_cnt1 = cnt_q[1];
  assign o_pkt_cnt2 = cnt_q[2];

endmodule

// File: tb/tb_ips2l_pcie_dma_tlp_tx_arb.sv
// Bench for the TLP TX arbiter: cycle-level vector table plus directed arbitration,
// backpressure and enable sequences.
module tb_ips2l_pcie_dma_tlp_tx_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   en, vld, last;
  logic [31:0]  d_ch [3];
  logic         m_trdy, clr;
  logic         o_s0_trdy, o_s1_trdy, o_s2_trdy;
  logic         o_m_tvld, o_m_tlast, o_m_tuser, o_busy;
  logic [127:0] o_m_tdata;
  logic [1:0]   o_grant;
  logic [15:0]  o_pkt_cnt0, o_pkt_cnt1, o_pkt_cnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [127:0] mk(input logic [1:0] ch, input logic [31:0] d);
    return {30'd0, ch, 32'hC0DE_0000, 32'h1234_5678, d};
  endfunction

  ips2l_pcie_dma_tlp_tx_arb #(.CPLD_PRIO(1), .CPLD_BURST_MAX(4)) dut (
    .clk(clk), .rst(rst), .i_ch_en(en),
    .i_s0_tvld(vld[0]), .o_s0_trdy(o_s0_trdy), .i_s0_tdata(mk(2'd0, d_ch[0])),
    .i_s0_tlast(last[0]), .i_s0_tuser(d_ch[0][0]),
    .i_s1_tvld(vld[1]), .o_s1_trdy(o_s1_trdy), .i_s1_tdata(mk(2'd1, d_ch[1])),
    .i_s1_tlast(last[1]), .i_s1_tuser(d_ch[1][0]),
    .i_s2_tvld(vld[2]), .o_s2_trdy(o_s2_trdy), .i_s2_tdata(mk(2'd2, d_ch[2])),
    .i_s2_tlast(last[2]), .i_s2_tuser(d_ch[2][0]),
    .o_m_tvld(o_m_tvld), .i_m_trdy(m_trdy), .o_m_tdata(o_m_tdata),
    .o_m_tlast(o_m_tlast), .o_m_tuser(o_m_tuser),
    .o_grant(o_grant), .o_busy(o_busy), .i_cnt_clr(clr),
    .o_pkt_cnt0(o_pkt_cnt0), .o_pkt_cnt1(o_pkt_cnt1), .o_pkt_cnt2(o_pkt_cnt2)
  );

  task automatic chk(input string nm, input logic [131:0] act, input logic [131:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor samples 1 ns before each posedge; drivers change inputs 1 ns after each negedge.
  logic [1:0]   prev_g = 2'd3;
  logic         stall_prev = 1'b0;
  logic [128:0] held;
  logic [2:0]   hs_s = '0;
  logic [1:0]   glog [$];
  logic [128:0] olog [$];

  always begin
    @(negedge clk);
    #4;
    hs_s = {o_s2_trdy & vld[2], o_s1_trdy & vld[1], o_s0_trdy & vld[0]};
    if (rst) begin
      prev_g     = 2'd3;
      stall_prev = 1'b0;
    end else begin
      if (o_grant != 2'd3 && prev_g == 2'd3) glog.push_back(o_grant);
      prev_g = o_grant;
      if (stall_prev) chk("hold", 132'({o_m_tvld, o_m_tlast, o_m_tdata}), 132'({1'b1, held}));
      if (o_m_tvld && m_trdy) olog.push_back({o_m_tlast, o_m_tdata});
      stall_prev = o_m_tvld && !m_trdy;
      held       = {o_m_tlast, o_m_tdata};
    end
  end

  typedef struct {
    logic        rst;
    logic [2:0]  vld, last;
    logic [31:0] d;
    logic        clr;
    logic [2:0]  x_trdy;
    logic [1:0]  x_g;
    logic        x_mv;
    logic [1:0]  x_mch;
    logic [31:0] x_md;
    logic        x_ml, x_busy, x_zero;
    logic [15:0] x_c0, x_c1, x_c2;
  } vec_t;

  vec_t vecs [$];

  function automatic void add(int r, int vl, int la, int d, int cl, int xt, int xg, int xmv,
                              int xmch, int xmd, int xml, int xb, int xz, int c0, int c1, int c2);
    vec_t v;
    v.rst = 1'(r);     v.vld = 3'(vl);    v.last = 3'(la);   v.d = 32'(d);    v.clr = 1'(cl);
    v.x_trdy = 3'(xt); v.x_g = 2'(xg);    v.x_mv = 1'(xmv);  v.x_mch = 2'(xmch);
    v.x_md = 32'(xmd); v.x_ml = 1'(xml);  v.x_busy = 1'(xb); v.x_zero = 1'(xz);
    v.x_c0 = 16'(c0);  v.x_c1 = 16'(c1);  v.x_c2 = 16'(c2);
    vecs.push_back(v);
  endfunction

  task automatic reset_dut();
    @(negedge clk); #1;
    rst = 1'b1; vld = '0; last = '0; clr = 1'b0; m_trdy = 1'b1; en = 3'b111;
    @(negedge clk); #1;
    rst = 1'b0;
    glog.delete();
    olog.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  int  k, alt_bad, expg;
  bit  done;

  initial begin
    rst = 1'b1; en = 3'b111; vld = '0; last = '0; m_trdy = 1'b1; clr = 1'b0;
    for (int i = 0; i < 3; i++) d_ch[i] = '0;
    reset_dut();

    // rst vld last d clr | trdy g mv mch md ml busy zero c0 c1 c2
    add(0,'b100,'b000,'h100,0, 'b000,3,0,0,0,0,0,1, 0,0,0);
    add(0,'b100,'b000,'h100,0, 'b100,2,0,0,0,0,1,0, 0,0,0);
    add(0,'b100,'b000,'h101,0, 'b100,2,1,2,'h100,0,1,0, 0,0,0);
    add(0,'b100,'b100,'h102,0, 'b100,2,1,2,'h101,0,1,0, 0,0,0);
    add(0,'b000,'b000,'h102,0, 'b000,3,1,2,'h102,1,1,0, 0,0,1);
    add(0,'b000,'b000,'h102,0, 'b000,3,0,0,0,0,0,0, 0,0,1);
    add(0,'b001,'b000,'h200,0, 'b000,3,0,0,0,0,0,0, 0,0,1);
    add(0,'b001,'b000,'h200,0, 'b001,0,0,0,0,0,1,0, 0,0,1);
    add(0,'b001,'b000,'h201,0, 'b001,0,1,0,'h200,0,1,0, 0,0,1);
    add(1,'b001,'b000,'h202,0, 'b001,0,1,0,'h201,0,1,0, 0,0,1);
    add(0,'b000,'b000,'h202,0, 'b000,3,0,0,0,0,0,1, 0,0,0);
    add(0,'b001,'b001,'h300,0, 'b000,3,0,0,0,0,0,0, 0,0,0);
    add(0,'b001,'b001,'h300,0, 'b001,0,0,0,0,0,1,0, 0,0,0);
    add(0,'b001,'b001,'h301,0, 'b000,3,1,0,'h300,1,1,0, 1,0,0);
    add(0,'b001,'b001,'h301,1, 'b001,0,0,0,0,0,1,0, 1,0,0);
    add(0,'b000,'b000,'h301,0, 'b000,3,1,0,'h301,1,1,0, 0,0,0);
    add(0,'b000,'b000,'h301,0, 'b000,3,0,0,0,0,0,0, 0,0,0);

    foreach (vecs[i]) begin
      @(negedge clk); #1;
      rst = vecs[i].rst; vld = vecs[i].vld; last = vecs[i].last; clr = vecs[i].clr;
      for (int c = 0; c < 3; c++) d_ch[c] = vecs[i].d;
      #2;
      chk($sformatf("v%0d_trdy", i), 132'({o_s2_trdy, o_s1_trdy, o_s0_trdy}), 132'(vecs[i].x_trdy));
      chk($sformatf("v%0d_grant", i), 132'(o_grant), 132'(vecs[i].x_g));
      chk($sformatf("v%0d_mtvld", i), 132'(o_m_tvld), 132'(vecs[i].x_mv));
      chk($sformatf("v%0d_busy", i), 132'(o_busy), 132'(vecs[i].x_busy));
      chk($sformatf("v%0d_cnt", i), 132'({o_pkt_cnt0, o_pkt_cnt1, o_pkt_cnt2}),
          132'({vecs[i].x_c0, vecs[i].x_c1, vecs[i].x_c2}));
      if (vecs[i].x_mv) begin
        chk($sformatf("v%0d_mdata", i),
            132'({o_m_tlast, o_m_tuser, o_m_tdata}),
            132'({vecs[i].x_ml, vecs[i].x_md[0], mk(vecs[i].x_mch, vecs[i].x_md)}));
      end
      if (vecs[i].x_zero) begin
        chk($sformatf("v%0d_zero", i), 132'({o_m_tlast, o_m_tuser, o_m_tdata}), 132'(0));
      end
    end

    // ch1/ch2 continuous single-beat TLPs: strict alternation, 50/50 after 100 TLPs.
    reset_dut();
    vld = 3'b110; last = 3'b110; done = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk); #1;
      if (32'(o_pkt_cnt1) + 32'(o_pkt_cnt2) >= 100) begin
        vld = '0; done = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge clk);
    chk("t2_done", 132'(done), 132'(1));
    chk("t2_ngrant", 132'(glog.size()), 132'(100));
    alt_bad = 0;
    foreach (glog[i]) if (glog[i] != ((i % 2 == 1) ? 2'd2 : 2'd1)) alt_bad++;
    chk("t2_alt", 132'(alt_bad), 132'(0));
    chk("t2_cnt", 132'({o_pkt_cnt1, o_pkt_cnt2}), 132'({16'd50, 16'd50}));

    // All three requesting: ch0 bursts of 4 separated by one ch1/ch2 grant.
    reset_dut();
    vld = 3'b111; last = 3'b111; done = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk); #1;
      if (32'(o_pkt_cnt0) + 32'(o_pkt_cnt1) + 32'(o_pkt_cnt2) >= 20) begin
        vld = '0; done = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge clk);
    chk("t3_done", 132'(done), 132'(1));
    chk("t3_ngrant", 132'(glog.size()), 132'(20));
    alt_bad = 0;
    foreach (glog[i]) begin
      expg = (i % 10 == 4) ? 1 : (i % 10 == 9) ? 2 : 0;
      if (32'(glog[i]) != expg) alt_bad++;
    end
    chk("t3_seq", 132'(alt_bad), 132'(0));
    chk("t3_cnt", 132'({o_pkt_cnt0, o_pkt_cnt1, o_pkt_cnt2}), 132'({16'd16, 16'd2, 16'd2}));

    // 4-beat ch0 TLP under random backpressure with ch2 waiting behind it.
    reset_dut();
    k = 0; d_ch[0] = 32'h40; last[0] = 1'b0; d_ch[2] = 32'h99; last[2] = 1'b1; vld = 3'b101;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk); #1;
      if (hs_s[0]) begin
        k++;
        if (k >= 4) vld[0] = 1'b0;
        else begin
          d_ch[0] = 32'h40 + 32'(k);
          last[0] = (k == 3);
        end
      end
      if (hs_s[2]) vld[2] = 1'b0;
      m_trdy = 1'($urandom_range(0, 1));
      if (olog.size() >= 5) break;
    end
    m_trdy = 1'b1; vld = '0;
    repeat (3) @(negedge clk);
    chk("t4_nbeat", 132'(olog.size()), 132'(5));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_beat%0d", i), 132'(olog[i]), 132'({(i == 3), mk(2'd0, 32'h40 + 32'(i))}));
    end
    chk("t4_beat4", 132'(olog[4]), 132'({1'b1, mk(2'd2, 32'h99)}));

    // ch1 enable cleared mid-packet: packet completes, no re-grant while disabled.
    reset_dut();
    k = 0; d_ch[1] = 32'h50; last[1] = 1'b0; vld = 3'b010;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (hs_s[1]) begin
        k++;
        if (k == 1) en[1] = 1'b0;
        if (k < 3) begin
          d_ch[1] = 32'h50 + 32'(k);
          last[1] = (k == 2);
        end else begin
          d_ch[1] = 32'h60;
          last[1] = 1'b0;
        end
      end
    end
    #2;
    chk("t5_cnt1", 132'(o_pkt_cnt1), 132'(1));
    chk("t5_ngrant", 132'(glog.size()), 132'(1));
    chk("t5_nbeat", 132'(olog.size()), 132'(3));
    chk("t5_lastbeat", 132'(olog[2]), 132'({1'b1, mk(2'd1, 32'h52)}));
    chk("t5_idle", 132'({o_grant, o_s1_trdy}), 132'({2'd3, 1'b0}));
    vld = '0; en = 3'b111;

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
